mem_access_stage: RTL

- MEM-stage data-memory access unit. Sits between the EX_MEM pipeline register and the MEM_WB pipeline register.
- Converts EX_MEM load/store control into a req/ack transaction on a variable-latency data memory.
- Registers the results into the MEM_WB input fields.
- Stalls upstream stages while a memory transaction is outstanding. Bounds each transaction with a timeout.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mem_access_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// FSM state encoding, error codes and datapath widths.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: turns EX_MEM load/store control into a req/ack memory
// transaction, stalls upstream while it is outstanding and bounds it with a timeout.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [WORD_W-1:0] ALU_result_in,
    input  logic [WORD_W-1:0] write_data_in,
    input  logic [REG_W-1:0]  EX_MEM_RegisterRd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              stall_out,
    output logic [WORD_W-1:0] D_MEM_read_data_out,
    output logic [WORD_W-1:0] D_MEM_read_addr_out,
    output logic [REG_W-1:0]  RegisterRd_out,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic              valid_out,
    output logic              err_out,
    output logic [1:0]        err_code
);

    localparam int unsigned      CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

    // Instruction fields captured at acceptance, replayed to MEM_WB on ack.
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              load_q, load_d;

    logic [WORD_W-1:0] rdata_out_q, rdata_out_d;
    logic [WORD_W-1:0] raddr_out_q, raddr_out_d;
    logic [REG_W-1:0]  rd_out_q, rd_out_d;
    logic              regwrite_out_q, regwrite_out_d;
    logic              memtoreg_out_q, memtoreg_out_d;
    logic              valid_out_q, valid_out_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic is_mem, misaligned, illegal, timeout_hit;

    always_comb begin
        is_mem      = MemRead_in | MemWrite_in;
        misaligned  = |ALU_result_in[1:0];
        illegal     = MemRead_in & MemWrite_in;
        timeout_hit = (state_q == StBusy) & (cnt_q == CntLast) & ~mem_ack;

        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = rd_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        load_d      = load_q;
        stall_out   = 1'b0;

        // MEM_WB side defaults to a bubble every edge.
        rdata_out_d    = '0;
        raddr_out_d    = '0;
        rd_out_d       = '0;
        regwrite_out_d = 1'b0;
        memtoreg_out_d = 1'b0;
        valid_out_d    = 1'b0;
        err_d          = 1'b0;
        err_code_d     = ERR_NONE;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (!is_mem) begin
                        valid_out_d    = 1'b1;
                        raddr_out_d    = ALU_result_in;
                        rd_out_d       = EX_MEM_RegisterRd_in;
                        regwrite_out_d = RegWrite_in;
                        memtoreg_out_d = MemtoReg_in;
                    end else if (misaligned || illegal) begin
                        err_d      = 1'b1;
                        err_code_d = illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                    end else begin
                        stall_out   = 1'b1;
                        state_d     = StBusy;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite_in;
                        mem_addr_d  = ALU_result_in;
                        mem_wdata_d = write_data_in;
                        rd_d        = EX_MEM_RegisterRd_in;
                        regwrite_d  = RegWrite_in;
                        memtoreg_d  = MemtoReg_in;
                        load_d      = MemRead_in;
                    end
                end
            end
            StBusy: begin
                stall_out = ~mem_ack & ~timeout_hit;
                if (mem_ack) begin
                    state_d        = StIdle;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_addr_d     = '0;
                    mem_wdata_d    = '0;
                    valid_out_d    = 1'b1;
                    rdata_out_d    = load_q ? mem_rdata : '0;
                    raddr_out_d    = mem_addr_q;
                    rd_out_d       = rd_q;
                    regwrite_out_d = regwrite_q;
                    memtoreg_out_d = memtoreg_q;
                end else if (timeout_hit) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    err_d       = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rd_q           <= '0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            load_q         <= 1'b0;
            rdata_out_q    <= '0;
            raddr_out_q    <= '0;
            rd_out_q       <= '0;
            regwrite_out_q <= 1'b0;
            memtoreg_out_q <= 1'b0;
            valid_out_q    <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rd_q           <= rd_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            load_q         <= load_d;
            rdata_out_q    <= rdata_out_d;
            raddr_out_q    <= raddr_out_d;
            rd_out_q       <= rd_out_d;
            regwrite_out_q <= regwrite_out_d;
            memtoreg_out_q <= memtoreg_out_d;
            valid_out_q    <= valid_out_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

    assign mem_req             = mem_req_q;
    assign mem_we              = mem_we_q;
    assign mem_addr            = mem_addr_q;
    assign mem_wdata           = mem_wdata_q;
    assign D_MEM_read_data_out = rdata_out_q;
    assign D_MEM_read_addr_out = raddr_out_q;
    assign RegisterRd_out      = rd_out_q;
    assign RegWrite_out        = regwrite_out_q;
    assign MemtoReg_out        = memtoreg_out_q;
    assign valid_out           = valid_out_q;
    assign err_out             = err_q;
    assign err_code            = err_code_q;

endmodule
